// File: rtl/branch_resolve_bht_if.sv
// rtl/branch_resolve_bht_if.sv - fetch prediction, decode resolve and statistics bundle
// Signals:
//   pred_pc / pred_taken        : fetch-side prediction lookup
//   res_valid, res_stall        : decode qualifiers for the instruction being resolved
//   res_pc, res_op, res_rt      : decode instruction fields
//   res_a, res_b                : forwarded rs/rt operands, DW bits
//   res_pred_taken              : prediction that fetch carried for this instruction
//   res_is_branch/taken/link/mispredict : combinational resolve results
//   clr_stats                   : synchronous clear of both statistics counters
//   branch_cnt, mispred_cnt     : wrap-around statistics
// master = fetch/decode side, slave = branch_resolve_bht.
interface branch_resolve_bht_if #(
   parameter int DW = 32
);
   logic [31:0]   pred_pc;
   logic          pred_taken;
   logic          res_valid;
   logic          res_stall;
   logic [31:0]   res_pc;
   logic [5:0]    res_op;
   logic [4:0]    res_rt;
   logic [DW-1:0] res_a;
   logic [DW-1:0] res_b;
   logic          res_pred_taken;
   logic          res_is_branch;
   logic          res_taken;
   logic          res_link;
   logic          res_mispredict;
   logic          clr_stats;
   logic [31:0]   branch_cnt;
   logic [31:0]   mispred_cnt;

   modport master (
      output pred_pc, res_valid, res_stall, res_pc, res_op, res_rt,
             res_a, res_b, res_pred_taken, clr_stats,
      input  pred_taken, res_is_branch, res_taken, res_link, res_mispredict,
             branch_cnt, mispred_cnt
   );

   modport slave (
      input  pred_pc, res_valid, res_stall, res_pc, res_op, res_rt,
             res_a, res_b, res_pred_taken, clr_stats,
      output pred_taken, res_is_branch, res_taken, res_link, res_mispredict,
             branch_cnt, mispred_cnt
   );
endinterface

// File: rtl/branch_resolve_bht.sv
// rtl/branch_resolve_bht.sv - decode-stage branch resolve with 2-bit saturating-counter BHT
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (table to CNT_INIT, statistics to 0)
//   bus    : branch_resolve_bht_if.slave
//            pred_pc -> pred_taken (combinational table read)
//            res_* decode inputs -> res_is_branch/res_taken/res_link/res_mispredict
//            clr_stats -> branch_cnt/mispred_cnt cleared on the next edge
// A branch commits when valid, not stalled and decoded as a supported branch;
// only a commit trains the table and advances the statistics, one edge later.
module branch_resolve_bht #(
   parameter int         DW       = 32,
   parameter int         BHT_IDX  = 6,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic                 clk,
   input logic                 rst_n,
   branch_resolve_bht_if.slave bus
);
   localparam int ENTRIES = 1 << BHT_IDX;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   logic [1:0]         bht [ENTRIES];
   logic [BHT_IDX-1:0] pred_idx;
   logic [BHT_IDX-1:0] res_idx;
   logic               is_branch;
   logic               cond;
   logic               link;
   logic               commit;
   logic               a_neg;
   logic               a_zero;
   logic [31:0]        branch_cnt_q;
   logic [31:0]        mispred_cnt_q;
   logic               unused_pc_bits;

   assign pred_idx = bus.pred_pc[BHT_IDX+1:2];
   assign res_idx  = bus.res_pc[BHT_IDX+1:2];
   assign unused_pc_bits = ^{bus.pred_pc[31:BHT_IDX+2], bus.pred_pc[1:0],
                             bus.res_pc[31:BHT_IDX+2], bus.res_pc[1:0]};

   assign a_neg  = bus.res_a[DW-1];
   assign a_zero = (bus.res_a == '0);

   // cond is only ever set alongside is_branch, so it doubles as res_taken.
   always_comb begin
      is_branch = 1'b0;
      cond      = 1'b0;
      link      = 1'b0;
      case (bus.res_op)
         OP_BEQ: begin
            is_branch = 1'b1;
            cond      = (bus.res_a == bus.res_b);
         end
         OP_BNE: begin
            is_branch = 1'b1;
            cond      = (bus.res_a != bus.res_b);
         end
         OP_BLEZ: begin
            is_branch = 1'b1;
            cond      = a_neg | a_zero;
         end
         OP_BGTZ: begin
            is_branch = 1'b1;
            cond      = ~a_neg & ~a_zero;
         end
         OP_REGIMM: begin
            case (bus.res_rt)
               RT_BLTZ: begin
                  is_branch = 1'b1;
                  cond      = a_neg;
               end
               RT_BGEZ: begin
                  is_branch = 1'b1;
                  cond      = ~a_neg;
               end
               RT_BLTZAL: begin
                  is_branch = 1'b1;
                  cond      = a_neg;
                  link      = 1'b1;
               end
               RT_BGEZAL: begin
                  is_branch = 1'b1;
                  cond      = ~a_neg;
                  link      = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign bus.res_is_branch  = is_branch;
   assign bus.res_taken      = cond;
   assign bus.res_link       = link;
   assign bus.res_mispredict = bus.res_valid & is_branch & (cond != bus.res_pred_taken);

   assign commit = bus.res_valid & ~bus.res_stall & is_branch;

   // Read-before-write: the read sees the registered array, so a same-index
   // commit only becomes visible to fetch from the following cycle.
   assign bus.pred_taken = bht[pred_idx][1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= CNT_INIT;
         end
      end else if (commit) begin
         if (cond) begin
            if (bht[res_idx] != 2'b11) begin
               bht[res_idx] <= bht[res_idx] + 2'b01;
            end
         end else if (bht[res_idx] != 2'b00) begin
            bht[res_idx] <= bht[res_idx] - 2'b01;
         end
      end
   end

   // clr_stats wins over a simultaneous commit; the table still trains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (bus.clr_stats) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else if (commit) begin
         branch_cnt_q  <= branch_cnt_q + 32'd1;
         mispred_cnt_q <= mispred_cnt_q + {31'd0, bus.res_mispredict};
      end
   end

   assign bus.branch_cnt  = branch_cnt_q;
   assign bus.mispred_cnt = mispred_cnt_q;
endmodule
